// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the fetch unit
package riscv_pkg;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} fetch_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10
    } fault_code_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and single-beat instruction fetch for a non-pipelined core
module inst_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        PCSel,
    input  logic [31:0] target,
    output logic        fetch_fault,
    output logic [1:0]  fault_code
);

    localparam int CW = $clog2(TIMEOUT + 1);

    fetch_state_t  state, state_n;
    fault_code_t   fault;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   next_pc;

    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign inst_valid  = (state == HOLD);
    assign fault_code  = fault;
    assign fetch_fault = (fault != FAULT_NONE);

    // Next state and wait counter; REQ only advances once its request strobe is out
    always_comb begin
        next_pc = PCSel ? (target & ~32'h1) : pc_plus4;
        state_n = state;
        cnt_n   = cnt;
        case (state)
            REQ: begin
                cnt_n   = '0;
                state_n = imem_req ? WAIT : REQ;
            end
            WAIT: begin
                cnt_n = cnt + CW'(1);
                if (imem_rvalid)
                    state_n = HOLD;
                else if (cnt_n == CW'(TIMEOUT))
                    state_n = HALT;
            end
            HOLD:    if (retire) state_n = next_pc[1] ? HALT : REQ;
            default: state_n = HALT;
        endcase
    end

    // State, PC, captured instruction and sticky fault registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= REQ;
            cnt      <= '0;
            pc       <= RESET_PC;
            inst     <= NOP_INST;
            imem_req <= 1'b0;
            fault    <= FAULT_NONE;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            imem_req <= (state_n == REQ);
            if (state == WAIT && imem_rvalid)
                inst <= imem_rdata;
            if (state == WAIT && !imem_rvalid && state_n == HALT)
                fault <= FAULT_TIMEOUT;
            if (state == HOLD && retire) begin
                if (next_pc[1])
                    fault <= FAULT_MISALIGN;
                else
                    pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scenario tasks with a queue of expected fetched words
module tb_inst_fetch;
    import riscv_pkg::*;

    localparam int TIMEOUT = 64;

    logic        clk = 0;
    logic        rst = 1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 0;
    logic [31:0] imem_rdata = 0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire = 0;
    logic        PCSel = 0;
    logic [31:0] target = 0;
    logic        fetch_fault;
    logic [1:0]  fault_code;

    int          pass_cnt = 0;
    int          total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] addr;
    bit          seen;

    inst_fetch #(.RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .retire(retire), .PCSel(PCSel), .target(target),
        .fetch_fault(fetch_fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_req(output bit s);
        int i = 0;
        s = 0;
        while (!s && i < 50) begin
            s = imem_req;
            if (!s) begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    // Serves one fetch: lat empty WAIT cycles, then rvalid; expected word queued if it should be captured
    task automatic do_fetch(input int lat, input logic [31:0] d, input bit stray,
                            output bit s, output logic [31:0] a);
        wait_req(s);
        a = imem_addr;
        if (lat < TIMEOUT) exp_q.push_back(d);
        imem_rvalid = stray;
        imem_rdata  = 32'hBAD0_0BAD;
        repeat (lat) begin
            @(negedge clk);
            imem_rvalid = 0;
        end
        @(negedge clk);
        imem_rvalid = 1;
        imem_rdata  = d;
        @(negedge clk);
        imem_rvalid = 0;
        imem_rdata  = 0;
    endtask

    task automatic do_retire(input bit sel, input logic [31:0] tgt);
        retire = 1;
        PCSel  = sel;
        target = tgt;
        @(negedge clk);
        retire = 0;
        PCSel  = 0;
        target = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) $display("FAIL reset_pc: pc %h pc_plus4 %h want 0/4", pc, pc_plus4); else pass_cnt++;
        total++; if (inst !== NOP_INST || inst_valid !== 1'b0) $display("FAIL reset_inst: inst %h valid %b want %h/0", inst, inst_valid, NOP_INST); else pass_cnt++;
        total++; if (imem_req !== 1'b0 || fault_code !== 2'b00 || fetch_fault !== 1'b0) $display("FAIL reset_ctrl: req %b code %b fault %b want 0", imem_req, fault_code, fetch_fault); else pass_cnt++;
        rst = 0;
    endtask

    task automatic test_first_fetch();
        do_fetch(0, 32'h0050_0093, 0, seen, addr);
        total++; if (!seen || addr !== 32'h0) $display("FAIL first_req: seen %b addr %h want 1/0", seen, addr); else pass_cnt++;
        exp = exp_q.pop_front();
        total++; if (inst !== exp || inst_valid !== 1'b1) $display("FAIL first_inst: inst %h valid %b want %h/1", inst, inst_valid, exp); else pass_cnt++;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            exp = inst;
            do_retire(0, 32'h0);
            total++; if (inst_valid !== 1'b0 || inst !== exp) $display("FAIL seq_hold_%0d: valid %b inst %h want 0/%h", k, inst_valid, inst, exp); else pass_cnt++;
            do_fetch(0, 32'h0000_1000 + k, 0, seen, addr);
            total++; if (!seen || addr !== 32'(4 * k)) $display("FAIL seq_addr_%0d: seen %b addr %h want %h", k, seen, addr, 4 * k); else pass_cnt++;
            exp = exp_q.pop_front();
            total++; if (inst !== exp || inst_valid !== 1'b1) $display("FAIL seq_inst_%0d: inst %h valid %b want %h/1", k, inst, inst_valid, exp); else pass_cnt++;
        end
        total++; if (pc_plus4 !== 32'h10) $display("FAIL seq_plus4: got %h want 00000010", pc_plus4); else pass_cnt++;
    endtask

    task automatic test_branch();
        int reqs = 0;
        do_retire(1, 32'h0000_0101);
        total++; if (pc !== 32'h100) $display("FAIL jalr_pc: got %h want 00000100", pc); else pass_cnt++;
        do_fetch(0, 32'h0000_0067, 0, seen, addr);
        total++; if (!seen || addr !== 32'h100) $display("FAIL jalr_addr: seen %b addr %h want 00000100", seen, addr); else pass_cnt++;
        exp = exp_q.pop_front();
        total++; if (inst !== exp) $display("FAIL jalr_inst: got %h want %h", inst, exp); else pass_cnt++;
        do_retire(1, 32'h0000_0102);
        total++; if (fault_code !== 2'b01 || fetch_fault !== 1'b1) $display("FAIL misalign_code: code %b fault %b want 01/1", fault_code, fetch_fault); else pass_cnt++;
        total++; if (pc !== 32'h100 || inst_valid !== 1'b0) $display("FAIL misalign_pc: pc %h valid %b want 00000100/0", pc, inst_valid); else pass_cnt++;
        repeat (8) begin
            reqs += int'(imem_req);
            @(negedge clk);
        end
        total++; if (reqs != 0 || fault_code !== 2'b01) $display("FAIL misalign_halt: reqs %0d code %b want 0/01", reqs, fault_code); else pass_cnt++;
    endtask

    task automatic test_latency_stray();
        do_reset();
        do_fetch(10, 32'h00A0_0113, 1, seen, addr);
        exp = exp_q.pop_front();
        total++; if (!seen || inst !== exp || inst_valid !== 1'b1) $display("FAIL late_inst: inst %h valid %b want %h/1", inst, inst_valid, exp); else pass_cnt++;
        imem_rvalid = 1;
        imem_rdata  = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        imem_rvalid = 0;
        total++; if (inst !== exp || inst_valid !== 1'b1) $display("FAIL hold_stray: inst %h valid %b want %h/1", inst, inst_valid, exp); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int reqs = 0;
        do_retire(0, 32'h0);
        do_fetch(TIMEOUT, 32'h1111_1111, 0, seen, addr);
        total++; if (fault_code !== 2'b10 || fetch_fault !== 1'b1) $display("FAIL timeout_code: code %b fault %b want 10/1", fault_code, fetch_fault); else pass_cnt++;
        repeat (8) begin
            reqs += int'(imem_req);
            @(negedge clk);
        end
        total++; if (reqs != 0 || inst_valid !== 1'b0) $display("FAIL timeout_halt: reqs %0d valid %b want 0/0", reqs, inst_valid); else pass_cnt++;
        do_reset();
        do_fetch(TIMEOUT - 1, 32'h2222_2222, 0, seen, addr);
        exp = exp_q.pop_front();
        total++; if (inst !== exp || inst_valid !== 1'b1 || fault_code !== 2'b00) $display("FAIL edge_capture: inst %h valid %b code %b want %h/1/00", inst, inst_valid, fault_code, exp); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_retire(1, 32'hFFFF_FFFC);
        total++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) $display("FAIL wrap_top: pc %h plus4 %h want fffffffc/0", pc, pc_plus4); else pass_cnt++;
        do_fetch(0, 32'h3333_3333, 0, seen, addr);
        exp = exp_q.pop_front();
        total++; if (addr !== 32'hFFFF_FFFC || inst !== exp) $display("FAIL wrap_fetch: addr %h inst %h want fffffffc/%h", addr, inst, exp); else pass_cnt++;
        do_retire(0, 32'h0);
        total++; if (pc !== 32'h0 || fault_code !== 2'b00) $display("FAIL wrap_pc: pc %h code %b want 0/00", pc, fault_code); else pass_cnt++;
        do_fetch(0, 32'h4444_4444, 0, seen, addr);
        exp = exp_q.pop_front();
        total++; if (addr !== 32'h0 || inst !== exp) $display("FAIL wrap_next: addr %h inst %h want 0/%h", addr, inst, exp); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_retire(0, 32'h0);
        wait_req(seen);
        @(negedge clk);
        #2 rst = 1;
        #1;
        total++; if (pc !== 32'h0 || inst !== NOP_INST || inst_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL async_rst: pc %h inst %h valid %b req %b want 0/%h/0/0", pc, inst, inst_valid, imem_req, NOP_INST); else pass_cnt++;
        @(negedge clk);
        rst = 0;
        imem_rvalid = 1;
        imem_rdata  = 32'hCAFE_F00D;
        do_fetch(0, 32'h5555_5555, 0, seen, addr);
        exp = exp_q.pop_front();
        total++; if (!seen || addr !== 32'h0 || inst !== exp) $display("FAIL post_rst_fetch: seen %b addr %h inst %h want 1/0/%h", seen, addr, inst, exp); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_latency_stray();
        test_timeout();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the non-pipelined RISC-V core. It owns the program counter and issues single-beat reads to instruction memory. It presents the returned word on `inst` to the instruction decoder/controller and holds it until the core retires the instruction. On retire it advances the PC by 4, or redirects to the ALU-computed target when `PCSel` is asserted.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `TIMEOUT`, 64, maximum cycles to wait for `imem_rvalid` before faulting (≥ 2)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  read request strobe, one cycle per fetch
- `imem_addr`  out  32  word address of the request, equal to `pc`
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  read data
- `inst`  out  32  current instruction to the controller
- `inst_valid`  out  1  `inst` is valid and stable
- `pc`  out  32  address of the current instruction
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32
- `retire`  in  1  core has finished executing `inst`
- `PCSel`  in  1  take `target` instead of `pc_plus4` on retire
- `target`  in  32  branch/JALR target from the ALU
- `fetch_fault`  out  1  sticky: misaligned target or memory timeout
- `fault_code`  out  2  00 none, 01 misaligned target, 10 timeout

## Operation
FSM states are REQ, WAIT, HOLD and HALT. Reset state is REQ.
- **REQ**
  - `imem_req`=1 for exactly one cycle, with `imem_addr`=`pc`.
  - Clear the timeout counter. Go to WAIT.
- **WAIT**
  - If `imem_rvalid`=1: capture `inst` from `imem_rdata` and go to HOLD.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, set `fault_code`=10 and go to HALT.
- **HOLD**
  - `inst_valid`=1 and `inst` is held.
  - On `retire`=1, compute `next_pc` = `PCSel` ? {`target`[31:1],1'b0} : `pc_plus4`.
    - If `next_pc`[1] = 1: set `fault_code`=01 and go to HALT. `pc` is unchanged.
    - Otherwise `pc` <= `next_pc` and go to REQ.
- **HALT**
  - `inst_valid`=0, `imem_req`=0.
  - Remain here until `rst`.
- `fetch_fault` = (`fault_code` != 00).
- Inputs that are out of state are ignored:
  - `retire` is ignored outside HOLD.
  - `imem_rvalid` is ignored outside WAIT. This covers stray responses, including one arriving in the same cycle as `imem_req`.
  - `PCSel` and `target` are sampled only on the retire cycle.
- Bit 0 of `target` is always cleared (JALR semantics). The `pc` low two bits are always 00.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4
  - `inst`=32'h0000_0013 (NOP), `inst_valid`=0
  - `imem_req`=0, `fetch_fault`=0, `fault_code`=00
  - state REQ
- First `imem_req` is driven in the first clock cycle after `rst` deasserts.
- `imem_req` is registered from the state; it is high only in REQ.
- Minimum fetch latency:
  - cycle t: `imem_req`
  - cycle t+1: `imem_rvalid`
  - cycle t+2: `inst_valid`
- Minimum retire-to-next-`inst_valid` is 3 cycles.
- `inst_valid` falls in the cycle after retire. `inst` keeps its old value until the next capture.
- `pc`/`pc_plus4` update at the retire edge. They are stable throughout REQ, WAIT and HOLD.
- Timeout fault: the edge on which the WAIT counter equals `TIMEOUT` with no `rvalid` enters HALT. A `rvalid` on that same cycle wins: capture the word, no fault.
- Wrap-around: `pc`=32'hFFFF_FFFC with `PCSel`=0 retires to 32'h0000_0000, no fault.
- Asynchronous `rst` mid-operation (any state, including mid-WAIT or HALT) immediately forces all reset values. A late `rvalid` after reset, seen in REQ, is ignored.

## Structure
- Shared package `riscv_pkg`:
  - `fetch_state_t` enum {REQ, WAIT, HOLD, HALT}
  - `fault_code_t` (2-bit) with constants FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT
  - `NOP_INST` = 32'h0000_0013
- Single module, no sub-module. The timeout counter is `$clog2(TIMEOUT+1)` bits wide, inline.

## Test plan
- **Reset/first fetch:** release `rst`, memory returns 32'h0050_0093 one cycle after req → `imem_addr`=0, `inst`=32'h0050_0093 with `inst_valid`=1 two cycles after req.
- **Sequential flow:** retire with `PCSel`=0 at `pc`=0x8 → next `imem_addr`=0xC, `pc_plus4`=0x10.
- **Branch/JALR:** retire with `PCSel`=1, `target`=0x0000_0101 → `pc`=0x100. Retire with `target`=0x102 → `fault_code`=01, HALT, `pc` unchanged, `inst_valid`=0.
- **Variable latency and stray data:** `rvalid` asserted during the REQ cycle and during HOLD → ignored. `rvalid` after 10 WAIT cycles → word captured.
- **Timeout:** withhold `rvalid` for `TIMEOUT` cycles → `fault_code`=10, `fetch_fault`=1, no further `imem_req`. Repeat with `rvalid` arriving exactly on cycle `TIMEOUT` → word captured, no fault.
- **Wrap and async reset:** `pc`=0xFFFF_FFFC retire → `pc`=0. Assert `rst` mid-WAIT → `inst`=NOP, `pc`=`RESET_PC`, and fresh req after release.
